// File: rtl/instruction_memory_loader_if.sv
// Byte-stream input and instruction-memory write bus for the loader.
// The master side is the loader itself; the slave side feeds bytes and observes writes.
interface instruction_memory_loader_if #(
   parameter int unsigned ADDR_WIDTH = 64
);
   logic [7:0]            byteIn;
   logic                  byteValid;
   logic                  byteReady;
   logic                  writeEnable;
   logic [ADDR_WIDTH-1:0] writeAddress;
   logic [31:0]           writeData;

   modport master (
      input  byteIn,
      input  byteValid,
      output byteReady,
      output writeEnable,
      output writeAddress,
      output writeData
   );

   modport slave (
      output byteIn,
      output byteValid,
      input  byteReady,
      input  writeEnable,
      input  writeAddress,
      input  writeData
   );
endinterface

// File: rtl/instruction_memory_loader.sv
// Assembles an MSB-first byte stream into 32-bit words and writes them to consecutive
// instruction-memory word addresses, truncating loads that would run past DEPTH.
module instruction_memory_loader #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DEPTH      = 1001
) (
   input  logic                             clock,
   input  logic                             resetN,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            baseAddress,
   input  logic [15:0]                      wordCount,
   instruction_memory_loader_if.master      mem,
   output logic                             busy,
   output logic                             done,
   output logic                             overflow
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StLoad  = 2'd1;
   localparam logic [1:0] StWrite = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [15:0]           eff_q, eff_d;
   logic                  ovf_q, ovf_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [15:0]           word_cnt_q, word_cnt_d;
   logic [31:0]           word_q, word_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [31:0]           wdata_q, wdata_d;

   logic [ADDR_WIDTH:0]   base_ext;
   logic [ADDR_WIDTH:0]   end_ext;
   logic                  trunc;
   logic [15:0]           eff_cnt;

   // One extra bit so base+count cannot wrap before comparing against DEPTH.
   always_comb begin
      base_ext = {1'b0, baseAddress};
      end_ext  = base_ext + (ADDR_WIDTH + 1)'(wordCount);
      trunc    = end_ext > DepthExt;
      if (base_ext >= DepthExt) begin
         eff_cnt = 16'd0;
      end else if (trunc) begin
         eff_cnt = 16'(DepthExt - base_ext);
      end else begin
         eff_cnt = wordCount;
      end
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      eff_d      = eff_q;
      ovf_d      = ovf_q;
      byte_cnt_d = byte_cnt_q;
      word_cnt_d = word_cnt_q;
      word_d     = word_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               base_d     = baseAddress;
               eff_d      = eff_cnt;
               ovf_d      = trunc;
               byte_cnt_d = 2'd0;
               word_cnt_d = 16'd0;
               word_d     = 32'd0;
               state_d    = (eff_cnt == 16'd0) ? StDone : StLoad;
            end
         end
         StLoad: begin
            if (mem.byteValid) begin
               word_d     = {word_q[23:0], mem.byteIn};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  // Register the write bus on entry so it is stable for the whole WRITE cycle.
                  waddr_d = base_q + ADDR_WIDTH'(word_cnt_q);
                  wdata_d = {word_q[23:0], mem.byteIn};
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            word_cnt_d = word_cnt_q + 16'd1;
            state_d    = (word_cnt_q + 16'd1 == eff_q) ? StDone : StLoad;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q    <= StIdle;
         base_q     <= '0;
         eff_q      <= 16'd0;
         ovf_q      <= 1'b0;
         byte_cnt_q <= 2'd0;
         word_cnt_q <= 16'd0;
         word_q     <= 32'd0;
         waddr_q    <= '0;
         wdata_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         eff_q      <= eff_d;
         ovf_q      <= ovf_d;
         byte_cnt_q <= byte_cnt_d;
         word_cnt_q <= word_cnt_d;
         word_q     <= word_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end

   always_comb begin
      mem.byteReady    = (state_q == StLoad);
      mem.writeEnable  = (state_q == StWrite);
      mem.writeAddress = waddr_q;
      mem.writeData    = wdata_q;
      busy             = (state_q != StIdle);
      done             = (state_q == StDone);
      overflow         = ovf_q;
   end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: one task per scenario, inline expected values.
module tb_instruction_memory_loader;

   logic        clock;
   logic        resetN;
   logic        start;
   logic [63:0] baseAddress;
   logic [15:0] wordCount;
   logic        busy;
   logic        done;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          done_cnt;
   logic        ovf_at_done;

   instruction_memory_loader_if #(.ADDR_WIDTH(64)) bus ();

   instruction_memory_loader #(
      .ADDR_WIDTH(64),
      .DEPTH     (1001)
   ) dut (
      .clock      (clock),
      .resetN     (resetN),
      .start      (start),
      .baseAddress(baseAddress),
      .wordCount  (wordCount),
      .mem        (bus.master),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Records every write strobe and done pulse seen at a rising edge.
   always @(posedge clock) begin
      if (bus.writeEnable === 1'b1) begin
         wr_addr.push_back(bus.writeAddress);
         wr_data.push_back(bus.writeData);
      end
      if (done === 1'b1) begin
         done_cnt    = done_cnt + 1;
         ovf_at_done = overflow;
      end
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      done_cnt    = 0;
      ovf_at_done = 1'b0;
   endtask

   task automatic do_start(input logic [63:0] base, input logic [15:0] cnt);
      start       = 1'b1;
      baseAddress = base;
      wordCount   = cnt;
      @(negedge clock);
      start       = 1'b0;
   endtask

   // Called at a falling edge; returns at the falling edge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      for (int i = 0; i < gap; i++) begin
         bus.byteValid = 1'b0;
         @(negedge clock);
      end
      bus.byteValid = 1'b1;
      bus.byteIn    = b;
      t = 0;
      while (bus.byteReady !== 1'b1 && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (t >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL byte_accept_timeout: byteReady=%b required 1", bus.byteReady);
      end
      @(negedge clock);
      bus.byteValid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (done !== 1'b1 && t < 60) begin
         @(negedge clock);
         t++;
      end
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_done_timeout: done=%b required 1", name, done);
      end
   endtask

   task automatic test_reset();
      resetN        = 1'b0;
      start         = 1'b0;
      baseAddress   = '0;
      wordCount     = '0;
      bus.byteIn    = 8'h00;
      bus.byteValid = 1'b0;
      clear_log();
      #1;
      n_checks++;
      if ({bus.byteReady, bus.writeEnable, busy, done, overflow} !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 00000",
                  {bus.byteReady, bus.writeEnable, busy, done, overflow});
      end
      n_checks++;
      if (bus.writeAddress !== 64'd0 || bus.writeData !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_bus: addr=%0h data=%0h required 0/0",
                  bus.writeAddress, bus.writeData);
      end
      repeat (2) @(negedge clock);
      resetN = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_single_word();
      logic [7:0] b[4] = '{8'h8B, 8'h1F, 8'h03, 8'hE5};
      clear_log();
      do_start(64'd0, 16'd1);
      for (int i = 0; i < 4; i++) send_byte(b[i], 0);
      n_checks++;
      if (bus.writeEnable !== 1'b1 || bus.byteReady !== 1'b0) begin
         n_fail++;
         $display("FAIL single_write_strobe: we=%b rdy=%b required 1/0",
                  bus.writeEnable, bus.byteReady);
      end
      n_checks++;
      if (bus.writeAddress !== 64'd0 || bus.writeData !== 32'h8B1F03E5) begin
         n_fail++;
         $display("FAIL single_write_bus: addr=%0h data=%h required 0/8b1f03e5",
                  bus.writeAddress, bus.writeData);
      end
      @(negedge clock);
      n_checks++;
      if (done !== 1'b1 || overflow !== 1'b0 || bus.writeEnable !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: done=%b ovf=%b we=%b required 1/0/0",
                  done, overflow, bus.writeEnable);
      end
      @(negedge clock);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || wr_addr.size() != 1) begin
         n_fail++;
         $display("FAIL single_after: done=%b busy=%b writes=%0d required 0/0/1",
                  done, busy, wr_addr.size());
      end
   endtask

   task automatic test_multi_word();
      logic [31:0] w[4] = '{32'h8B1F03E5, 32'hF84000A4, 32'h8B040086, 32'hF80010A6};
      logic [31:0] cur;
      clear_log();
      do_start(64'd10, 16'd4);
      for (int i = 0; i < 4; i++) begin
         cur = w[i];
         send_byte(cur[31:24], (i + 0) % 3);
         send_byte(cur[23:16], (i + 1) % 3);
         send_byte(cur[15:8],  (i + 2) % 3);
         send_byte(cur[7:0],   (i + 1) % 2);
      end
      wait_done("multi");
      repeat (3) @(negedge clock);
      n_checks++;
      if (wr_addr.size() != 4 || done_cnt != 1 || ovf_at_done !== 1'b0) begin
         n_fail++;
         $display("FAIL multi_counts: writes=%0d dones=%0d ovf=%b required 4/1/0",
                  wr_addr.size(), done_cnt, ovf_at_done);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_addr[i] !== 64'(10 + i) || wr_data[i] !== w[i]) begin
               n_fail++;
               $display("FAIL multi_write%0d: addr=%0d data=%h required %0d/%h",
                        i, wr_addr[i], wr_data[i], 10 + i, w[i]);
            end
         end
      end
   endtask

   task automatic test_zero_count();
      clear_log();
      do_start(64'd5, 16'd0);
      n_checks++;
      if (done !== 1'b1 || bus.byteReady !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_done: done=%b rdy=%b busy=%b required 1/0/1",
                  done, bus.byteReady, busy);
      end
      @(negedge clock);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || bus.byteReady !== 1'b0 || wr_addr.size() != 0) begin
         n_fail++;
         $display("FAIL zero_after: done=%b busy=%b rdy=%b writes=%0d required 0/0/0/0",
                  done, busy, bus.byteReady, wr_addr.size());
      end
   endtask

   task automatic test_truncation();
      logic [7:0] b[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
      clear_log();
      do_start(64'd999, 16'd5);
      for (int i = 0; i < 8; i++) send_byte(b[i], i % 2);
      n_checks++;
      if (bus.writeEnable !== 1'b1 || bus.writeAddress !== 64'd1000 ||
          bus.writeData !== 32'hA1B2C3D4) begin
         n_fail++;
         $display("FAIL trunc_last_write: we=%b addr=%0d data=%h required 1/1000/a1b2c3d4",
                  bus.writeEnable, bus.writeAddress, bus.writeData);
      end
      @(negedge clock);
      n_checks++;
      if (done !== 1'b1 || overflow !== 1'b1 || bus.byteReady !== 1'b0) begin
         n_fail++;
         $display("FAIL trunc_done: done=%b ovf=%b rdy=%b required 1/1/0",
                  done, overflow, bus.byteReady);
      end
      repeat (3) @(negedge clock);
      n_checks++;
      if (wr_addr.size() != 2 || bus.byteReady !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL trunc_after: writes=%0d rdy=%b busy=%b required 2/0/0",
                  wr_addr.size(), bus.byteReady, busy);
      end else begin
         n_checks++;
         if (wr_addr[0] !== 64'd999 || wr_data[0] !== 32'h01020304) begin
            n_fail++;
            $display("FAIL trunc_first_write: addr=%0d data=%h required 999/01020304",
                     wr_addr[0], wr_data[0]);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      clear_log();
      do_start(64'd0, 16'd3);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      resetN = 1'b0;
      #1;
      n_checks++;
      if ({bus.byteReady, bus.writeEnable, busy, done, overflow} !== 5'b00000 ||
          bus.writeAddress !== 64'd0 || bus.writeData !== 32'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: flags=%b addr=%0h data=%h required 00000/0/0",
                  {bus.byteReady, bus.writeEnable, busy, done, overflow},
                  bus.writeAddress, bus.writeData);
      end
      @(negedge clock);
      resetN = 1'b1;
      @(negedge clock);
      clear_log();
      do_start(64'd20, 16'd1);
      send_byte(8'h11, 0);
      send_byte(8'h22, 1);
      send_byte(8'h33, 0);
      send_byte(8'h44, 2);
      wait_done("midreset");
      @(negedge clock);
      n_checks++;
      if (wr_addr.size() != 1 || wr_addr[0] !== 64'd20 || wr_data[0] !== 32'h11223344) begin
         n_fail++;
         $display("FAIL midreset_reload: writes=%0d addr=%0d data=%h required 1/20/11223344",
                  wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : 64'd0,
                  wr_data.size() > 0 ? wr_data[0] : 32'd0);
      end
   endtask

   task automatic test_start_while_busy();
      clear_log();
      do_start(64'd30, 16'd2);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      do_start(64'd50, 16'd7);
      send_byte(8'hBE, 0);
      send_byte(8'hEF, 0);
      send_byte(8'hCA, 1);
      send_byte(8'hFE, 0);
      send_byte(8'hF0, 2);
      send_byte(8'h0D, 0);
      wait_done("busystart");
      repeat (3) @(negedge clock);
      n_checks++;
      if (wr_addr.size() != 2 || done_cnt != 1 || ovf_at_done !== 1'b0) begin
         n_fail++;
         $display("FAIL busystart_counts: writes=%0d dones=%0d ovf=%b required 2/1/0",
                  wr_addr.size(), done_cnt, ovf_at_done);
      end else begin
         n_checks++;
         if (wr_addr[0] !== 64'd30 || wr_data[0] !== 32'hDEADBEEF ||
             wr_addr[1] !== 64'd31 || wr_data[1] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL busystart_writes: %0d:%h %0d:%h required 30:deadbeef 31:cafef00d",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_multi_word();
      test_zero_count();
      test_truncation();
      test_reset_mid_load();
      test_start_while_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_memory_loader.md
INSTRUCTION_MEMORY_LOADER -- requirements
Module: instruction_memory_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, sets the width of the word address driven to instruction memory.
REQ-002 Parameter DEPTH, default 1001, sets the number of writable instruction words (word addresses 0..DEPTH-1).
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: one-cycle request to begin a load; sampled only in IDLE.
REQ-006 Port baseAddress, input, ADDR_WIDTH bits: first word address; latched when start is accepted.
REQ-007 Port wordCount, input, 16 bits: number of 32-bit words to load; latched when start is accepted.
REQ-008 Port byteIn, input, 8 bits: serial instruction byte stream.
REQ-009 Port byteValid, input, 1 bit: byteIn holds a valid byte.
REQ-010 Port byteReady, output, 1 bit: loader accepts a byte this cycle.
REQ-011 Port writeEnable, output, 1 bit: one-cycle write strobe to instruction memory.
REQ-012 Port writeAddress, output, ADDR_WIDTH bits: word address for the current write.
REQ-013 Port writeData, output, 32 bits: instruction word for the current write.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.
REQ-015 Port done, output, 1 bit: one-cycle pulse when a load completes.
REQ-016 Port overflow, output, 1 bit: valid with done; high if the load was truncated.

Function
REQ-017 The controller SHALL have states IDLE, LOAD, WRITE, DONE.
REQ-018 In IDLE, start=1 SHALL latch baseAddress and wordCount, clear the byte and word counters, and move to LOAD; if wordCount=0, it SHALL move to DONE instead.
REQ-019 Loads are truncated: if baseAddress+wordCount exceeds DEPTH, the effective count SHALL be DEPTH-baseAddress (0 if baseAddress>=DEPTH), and overflow SHALL be set for that load.
REQ-020 In LOAD, byteReady SHALL be 1; a byte transfers only on a cycle with byteValid=1 and byteReady=1.
REQ-021 Bytes SHALL assemble MSB-first: the first byte goes to bits 31:24 and the fourth to bits 7:0.
REQ-022 On the 4th accepted byte, the state SHALL move to WRITE.
REQ-023 In WRITE, for exactly one cycle:
  - writeEnable=1;
  - writeData = the assembled word;
  - writeAddress = baseAddress + number of words already written;
  - byteReady=0.
REQ-024 After WRITE, the word counter SHALL increment; the state SHALL move to DONE if it equals the effective count, else back to LOAD.
REQ-025 In DONE, done=1 for one cycle; the state then returns to IDLE.
REQ-026 writeAddress and writeData SHALL hold their last values outside WRITE; writeEnable SHALL be 0 outside WRITE.
REQ-027 start asserted in any state other than IDLE SHALL be ignored.
REQ-028 In LOAD, byteValid=0 SHALL stall the load indefinitely with no timeout and no change to the partial word.
REQ-029 Per-word latency SHALL be 4 accepted bytes plus 1 WRITE cycle; the minimum is 5 cycles per word.

Reset
REQ-030 While resetN=0, all of the following SHALL hold immediately (not waiting for a clock edge):
  - state = IDLE;
  - byteReady=0, writeEnable=0, busy=0, done=0, overflow=0;
  - writeAddress=0, writeData=0;
  - all counters and the partial word cleared.
REQ-031 Reset during LOAD or WRITE SHALL abandon the load with no further writes; the partial word is discarded.

Verification
REQ-032 Single word: start with baseAddress=0 and wordCount=1; send bytes 8B,1F,03,E5 back-to-back -> one writeEnable pulse with writeAddress=0 and writeData=32'h8B1F03E5; done pulses 5 cycles after the first byte; overflow=0.
REQ-033 Four words from base 10: words 8B1F03E5, F84000A4, 8B040086, F80010A6 with random byteValid gaps -> writes at addresses 10..13 in order with matching data; exactly one done pulse.
REQ-034 Zero count: start with wordCount=0 -> DONE on the next cycle; done=1 for one cycle; no writeEnable; byteReady stays 0.
REQ-035 Truncation: baseAddress=999, wordCount=5 -> writes only to addresses 999 and 1000; done with overflow=1; byteReady returns to 0 after the 8th byte.
REQ-036 Reset mid-load: assert resetN=0 after 2 bytes of word 1 -> outputs go to reset values asynchronously; a new start with 4 bytes writes the word built from those 4 new bytes only.
REQ-037 Start while busy: pulse start during LOAD with different baseAddress and wordCount -> ignored; the original load completes unchanged.
